// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bcd_pkg
// Brief    : Shared types and constants for the binary-to-BCD converter.
// Revision : 1.0 - initial release
// ============================================================================
package bcd_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int                      BCD_NIBBLE_W  = 4;
    localparam logic [BCD_NIBBLE_W-1:0] BCD_OVF_DIGIT = 4'hF;
    localparam logic [BCD_NIBBLE_W-1:0] BCD_ADJ_LIMIT = 4'd5;
    localparam logic [BCD_NIBBLE_W-1:0] BCD_ADJ_ADD   = 4'd3;

    // Bit counter must hold the value IN_W itself.
    function automatic int cnt_width(input int in_w);
        return (in_w < 1) ? 1 : $clog2(in_w + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bin_to_bcd_if.sv
`default_nettype none
// ============================================================================
// Module   : bin_to_bcd_if
// Brief    : Input handshake and BCD result bus of the converter.
// Revision : 1.0 - initial release
// ============================================================================
interface bin_to_bcd_if
    import bcd_pkg::*;
#(
    parameter int IN_W   = 32,
    parameter int DIGITS = 8
);

    logic                           in_valid;
    logic                           in_ready;
    logic [IN_W-1:0]                bin_in;
    logic [BCD_NIBBLE_W*DIGITS-1:0] bcd_out;
    logic                           out_valid;
    logic                           ovf;

    modport master (
        output in_valid,
        output bin_in,
        input  in_ready,
        input  bcd_out,
        input  out_valid,
        input  ovf
    );

    modport slave (
        input  in_valid,
        input  bin_in,
        output in_ready,
        output bcd_out,
        output out_valid,
        output ovf
    );

endinterface
`default_nettype wire

// File: rtl/bcd_digit_adj.sv
`default_nettype none
// ============================================================================
// Module   : bcd_digit_adj
// Brief    : Double-dabble nibble correction, adds 3 when the digit is >= 5.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [BCD_NIBBLE_W-1:0] din,
    output logic [BCD_NIBBLE_W-1:0] dout
);

    // 4-bit wrap is intended: no carry ever propagates into the next digit.
    assign dout = (din >= BCD_ADJ_LIMIT) ? (din + BCD_ADJ_ADD) : din;

endmodule
`default_nettype wire

// File: rtl/bin_to_bcd.sv
`default_nettype none
// ============================================================================
// Module   : bin_to_bcd
// Brief    : Sequential double-dabble converter, one input bit per clock.
// Revision : 1.0 - initial release
// ============================================================================
module bin_to_bcd
    import bcd_pkg::*;
#(
    parameter int IN_W   = 32,
    parameter int DIGITS = 8
) (
    input  logic        clk,
    input  logic        clr,
    bin_to_bcd_if.slave bus
);

    localparam int                 c_ACC_W    = BCD_NIBBLE_W * DIGITS;
    localparam int                 c_CNT_W    = cnt_width(IN_W);
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(IN_W);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    state_t             r_state;
    logic               r_ready;
    logic               r_out_valid;
    logic               r_ovf;
    logic               r_ovf_sticky;
    logic [c_CNT_W-1:0] r_cnt;
    logic [IN_W-1:0]    r_shift;
    logic [c_ACC_W-1:0] r_acc;
    logic [c_ACC_W-1:0] r_bcd;

    logic [c_ACC_W-1:0] w_adj;
    logic [c_ACC_W-1:0] w_acc_next;
    logic               w_ovf_next;

    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_digit
            bcd_digit_adj u_adj (
                .din  (r_acc[g*BCD_NIBBLE_W +: BCD_NIBBLE_W]),
                .dout (w_adj[g*BCD_NIBBLE_W +: BCD_NIBBLE_W])
            );
        end
    endgenerate

    // A 1 leaving the top digit means the value no longer fits the display.
    assign w_acc_next = {w_adj[c_ACC_W-2:0], r_shift[IN_W-1]};
    assign w_ovf_next = r_ovf_sticky | w_adj[c_ACC_W-1];

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state      <= IDLE;
            r_ready      <= 1'b1;
            r_out_valid  <= 1'b0;
            r_ovf        <= 1'b0;
            r_ovf_sticky <= 1'b0;
            r_cnt        <= '0;
            r_shift      <= '0;
            r_acc        <= '0;
            r_bcd        <= '0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_state      <= SHIFT;
                        r_ready      <= 1'b0;
                        r_shift      <= bus.bin_in;
                        r_acc        <= '0;
                        r_ovf_sticky <= 1'b0;
                        r_cnt        <= c_CNT_LOAD;
                    end
                end
                SHIFT: begin
                    r_acc        <= w_acc_next;
                    r_shift      <= r_shift << 1;
                    r_ovf_sticky <= w_ovf_next;
                    r_cnt        <= r_cnt - c_CNT_ONE;
                    if (r_cnt == c_CNT_ONE) begin
                        r_bcd       <= w_ovf_next ? {DIGITS{BCD_OVF_DIGIT}} : w_acc_next;
                        r_ovf       <= w_ovf_next;
                        r_out_valid <= 1'b1;
                        r_ready     <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_ready;
    assign bus.bcd_out   = r_bcd;
    assign bus.out_valid = r_out_valid;
    assign bus.ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_bin_to_bcd.sv
`default_nettype none
// ============================================================================
// Module   : tb_bin_to_bcd
// Brief    : Scoreboard bench for bin_to_bcd with directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bin_to_bcd;

    localparam int IN_W   = 32;
    localparam int DIGITS = 8;

    typedef struct {
        logic [31:0] bcd;
        logic        ovf;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic clr = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   pulses = 0;
    exp_t q[$];

    bin_to_bcd_if #(.IN_W(IN_W), .DIGITS(DIGITS)) bus ();

    bin_to_bcd #(.IN_W(IN_W), .DIGITS(DIGITS)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired (cycle %0d)", nm, cyc);
    endtask

    // Present a value, wait for acceptance, queue its expected result.
    task automatic send(input logic [31:0] v, input logic [31:0] exp_bcd, input logic exp_ovf);
        int n;
        exp_t e;
        n = 0;
        @(negedge clk);
        bus.bin_in   = v;
        bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) timeout_fail("accept");
        else begin
            e.bcd = exp_bcd;
            e.ovf = exp_ovf;
            e.cyc = cyc + 1 + IN_W;
            q.push_back(e);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (q.size() > 0) begin
            timeout_fail("result");
            q.delete();
        end
    endtask

    // Monitor: every out_valid pulse must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) begin
                pulses++;
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out_valid: got bcd %h ovf %b, required no result", bus.bcd_out, bus.ovf);
                end else begin
                    e = q.pop_front();
                    chk("bcd_out", bus.bcd_out, e.bcd);
                    chk("ovf", {31'b0, bus.ovf}, {31'b0, e.ovf});
                    chk("latency_cycle", cyc, e.cyc);
                    chk("in_ready_with_out_valid", {31'b0, bus.in_ready}, 32'd1);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        int   snap;
        exp_t e;
        bus.in_valid = 1'b0;
        bus.bin_in   = '0;

        #1 clr = 1'b1;
        #1;
        chk("reset_bcd_out", bus.bcd_out, 32'h0);
        chk("reset_ovf", {31'b0, bus.ovf}, 32'd0);
        chk("reset_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("reset_in_ready", {31'b0, bus.in_ready}, 32'd1);
        #10 clr = 1'b0;

        send(32'd12345678,  32'h12345678, 1'b0); drain();
        send(32'd0,         32'h00000000, 1'b0); drain();
        send(32'd99999999,  32'h99999999, 1'b0); drain();
        send(32'd9,         32'h00000009, 1'b0); drain();
        send(32'd100000000, 32'hFFFFFFFF, 1'b1); drain();
        send(32'hFFFFFFFF,  32'hFFFFFFFF, 1'b1); drain();
        send(32'd42,        32'h00000042, 1'b0); drain();

        // in_valid held high with junk data while busy; second accept on out_valid cycle.
        @(negedge clk);
        bus.bin_in   = 32'd31415926;
        bus.in_valid = 1'b1;
        e.bcd = 32'h31415926; e.ovf = 1'b0; e.cyc = cyc + 1 + IN_W;
        q.push_back(e);
        @(negedge clk);
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 100) begin
            bus.bin_in = $urandom;
            @(negedge clk);
            n++;
        end
        if (n >= 100) timeout_fail("hold_ready");
        bus.bin_in = 32'd27182818;
        e.bcd = 32'h27182818; e.ovf = 1'b0; e.cyc = cyc + 1 + IN_W;
        q.push_back(e);
        @(negedge clk);
        bus.in_valid = 1'b0;
        drain();

        // Asynchronous reset while idle clears a held overflow result at once.
        send(32'd100000000, 32'hFFFFFFFF, 1'b1); drain();
        @(negedge clk);
        #2 clr = 1'b1;
        #1;
        chk("async_clr_bcd_out", bus.bcd_out, 32'h0);
        chk("async_clr_ovf", {31'b0, bus.ovf}, 32'd0);
        chk("async_clr_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("async_clr_in_ready", {31'b0, bus.in_ready}, 32'd1);
        @(negedge clk);
        clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_clr_bcd_out", bus.bcd_out, 32'h0);
        chk("post_clr_ovf", {31'b0, bus.ovf}, 32'd0);

        // Abort a conversion part way through.
        send(32'd65536, 32'h00065536, 1'b0); drain();
        @(negedge clk);
        bus.bin_in   = 32'd87654321;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("abort_busy", {31'b0, bus.in_ready}, 32'd0);
        repeat (10) @(negedge clk);
        #2 clr = 1'b1;
        #1;
        chk("abort_bcd_out", bus.bcd_out, 32'h0);
        chk("abort_in_ready", {31'b0, bus.in_ready}, 32'd1);
        @(negedge clk);
        clr  = 1'b0;
        snap = pulses;
        repeat (40) @(negedge clk);
        chk("abort_no_out_valid", pulses, snap);
        chk("abort_bcd_held", bus.bcd_out, 32'h0);

        send(32'd555, 32'h00000555, 1'b0); drain();

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
